// File: rtl/alu_pkg.sv
// Shared ALU definitions: ALUControl opcode encoding and the seq_alu FSM state type.
package alu_pkg;

   localparam logic [2:0] OP_ADD = 3'b000;
   localparam logic [2:0] OP_SUB = 3'b001;
   localparam logic [2:0] OP_AND = 3'b010;
   localparam logic [2:0] OP_OR  = 3'b011;
   localparam logic [2:0] OP_XOR = 3'b100;
   localparam logic [2:0] OP_SLT = 3'b101;
   localparam logic [2:0] OP_MUL = 3'b110;
   localparam logic [2:0] OP_ILL = 3'b111;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_MUL  = 2'b01,
      ST_DONE = 2'b10
   } state_t;

endpackage

// File: rtl/mul_iter.sv
// Iterative shift-add multiplier: one partial product per step, low WIDTH bits kept.
// Loaded by start; after WIDTH steps product carries the final value on the step where last=1.
module mul_iter
   import alu_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             step,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             last,
   output logic [WIDTH-1:0] product
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   logic [WIDTH-1:0] acc;
   logic [WIDTH-1:0] mcand;
   logic [WIDTH-1:0] mplier;
   logic [CW-1:0]    cnt;

   // product is the accumulator after the current step, so the owner can capture it on the last step
   assign product = acc + (mplier[0] ? mcand : '0);
   assign last    = (cnt == CW'(WIDTH - 1));

   always_ff @(posedge clk) begin
      if (reset) begin
         acc    <= '0;
         mcand  <= '0;
         mplier <= '0;
         cnt    <= '0;
      end else if (start) begin
         acc    <= '0;
         mcand  <= a;
         mplier <= b;
         cnt    <= '0;
      end else if (step) begin
         acc    <= product;
         mcand  <= mcand << 1;
         mplier <= mplier >> 1;
         cnt    <= cnt + CW'(1);
      end
   end

endmodule

// File: rtl/seq_alu.sv
// Sequential ALU, valid/ready in and out; latency 1, or WIDTH+1 for mul when SEQ_ALU_MUL_EN is defined.
// Accepts only in IDLE; the result is held in DONE until out_ready.
module seq_alu
   import alu_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [2:0]       ALUControl,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             zero,
   output logic             illegal
);

   state_t           state;
   state_t           state_next;
   logic [WIDTH-1:0] alu_res;
   logic             alu_ill;
   logic             res_load;
   logic [WIDTH-1:0] res_next;
   logic             ill_next;

`ifdef SEQ_ALU_MUL_EN
   logic             mul_start;
   logic             mul_step;
   logic             mul_last;
   logic [WIDTH-1:0] mul_product;

   mul_iter #(.WIDTH(WIDTH)) u_mul (
      .clk     (clk),
      .reset   (reset),
      .start   (mul_start),
      .step    (mul_step),
      .a       (a),
      .b       (b),
      .last    (mul_last),
      .product (mul_product)
   );
`endif

   // Single-cycle operations; an unsupported code yields result 0 with illegal set
   always_comb begin
      alu_res = '0;
      alu_ill = 1'b0;
      case (ALUControl)
         OP_ADD: alu_res = a + b;
         OP_SUB: alu_res = a - b;
         OP_AND: alu_res = a & b;
         OP_OR:  alu_res = a | b;
         OP_XOR: alu_res = a ^ b;
         OP_SLT: alu_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
`ifdef SEQ_ALU_MUL_EN
         OP_MUL: alu_res = '0;
`endif
         default: alu_ill = 1'b1;
      endcase
   end

   always_comb begin
      state_next = state;
      res_load   = 1'b0;
      res_next   = alu_res;
      ill_next   = alu_ill;
`ifdef SEQ_ALU_MUL_EN
      mul_start  = 1'b0;
      mul_step   = 1'b0;
`endif
      case (state)
         ST_IDLE: begin
            if (in_valid) begin
`ifdef SEQ_ALU_MUL_EN
               if (ALUControl == OP_MUL) begin
                  mul_start  = 1'b1;
                  state_next = ST_MUL;
               end else begin
                  res_load   = 1'b1;
                  state_next = ST_DONE;
               end
`else
               res_load   = 1'b1;
               state_next = ST_DONE;
`endif
            end
         end
`ifdef SEQ_ALU_MUL_EN
         ST_MUL: begin
            mul_step = 1'b1;
            if (mul_last) begin
               res_load   = 1'b1;
               res_next   = mul_product;
               ill_next   = 1'b0;
               state_next = ST_DONE;
            end
         end
`endif
         ST_DONE: begin
            if (out_ready) state_next = ST_IDLE;
         end
         default: state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= ST_IDLE;
         result  <= '0;
         zero    <= 1'b0;
         illegal <= 1'b0;
      end else begin
         state <= state_next;
         if (res_load) begin
            result  <= res_next;
            zero    <= (res_next == '0);
            illegal <= ill_next;
         end
      end
   end

   assign in_ready  = (state == ST_IDLE);
   assign out_valid = (state == ST_DONE);

endmodule

// File: tb/tb_seq_alu.sv
// Self-checking bench for seq_alu: directed table, hand-written corner sequences, random ops vs. a reference model.
module tb_seq_alu;

   localparam int WIDTH = 32;
`ifdef SEQ_ALU_MUL_EN
   localparam bit MUL_EN = 1'b1;
`else
   localparam bit MUL_EN = 1'b0;
`endif

   logic             clk = 1'b0;
   logic             reset;
   logic             in_valid;
   logic             in_ready;
   logic [2:0]       ALUControl;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] result;
   logic             zero;
   logic             illegal;

   int vectors     = 0;
   int miscompares = 0;

   seq_alu #(.WIDTH(WIDTH)) dut (
      .clk        (clk),
      .reset      (reset),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .ALUControl (ALUControl),
      .a          (a),
      .b          (b),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .result     (result),
      .zero       (zero),
      .illegal    (illegal)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, got timeout required finish");
      $fatal(1, "watchdog");
   end

   typedef struct {
      logic [2:0]  op;
      logic [31:0] x;
      logic [31:0] y;
      logic [31:0] res;
      logic        z;
      logic        ill;
      int          lat;
   } vec_t;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   // Reference behaviour straight from the operation definitions
   function automatic void model(input logic [2:0] op, input logic [31:0] x, input logic [31:0] y,
                                 output logic [31:0] r, output logic ill, output int lat);
      logic [63:0] p;
      r   = '0;
      ill = 1'b0;
      lat = 1;
      case (op)
         3'd0: r = x + y;
         3'd1: r = x - y;
         3'd2: r = x & y;
         3'd3: r = x | y;
         3'd4: r = x ^ y;
         3'd5: r = ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
         3'd6: begin
            if (MUL_EN) begin
               p   = {32'd0, x} * {32'd0, y};
               r   = p[31:0];
               lat = WIDTH + 1;
            end else begin
               ill = 1'b1;
            end
         end
         default: ill = 1'b1;
      endcase
   endfunction

   // Called just after a rising edge with the block idle; returns just after the edge that frees it
   task automatic run_op(input logic [2:0] op, input logic [31:0] x, input logic [31:0] y,
                         output logic [31:0] r, output logic z, output logic il,
                         output int lat, output logic busy_ok);
      ALUControl = op;
      a          = x;
      b          = y;
      in_valid   = 1'b1;
      out_ready  = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      lat      = 1;
      busy_ok  = 1'b1;
      while (!out_valid && lat < 100) begin
         if (in_ready) busy_ok = 1'b0;
         @(posedge clk); #1;
         lat++;
      end
      r  = result;
      z  = zero;
      il = illegal;
      @(posedge clk); #1;
   endtask

   vec_t        tbl[$];
   logic [31:0] r_got;
   logic        z_got;
   logic        il_got;
   int          lat_got;
   logic        busy_ok;
   logic [31:0] r_exp;
   logic        il_exp;
   int          lat_exp;
   logic        stale;

   initial begin
      reset      = 1'b1;
      in_valid   = 1'b0;
      out_ready  = 1'b0;
      ALUControl = 3'd0;
      a          = '0;
      b          = '0;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      check("reset_out_valid", out_valid, 0);
      check("reset_in_ready", in_ready, 1);
      check("reset_result", result, 0);
      check("reset_zero", zero, 0);
      check("reset_illegal", illegal, 0);

      tbl.push_back('{3'd0, 32'd7,          32'd5,          32'd12,         1'b0, 1'b0, 1});
      tbl.push_back('{3'd1, 32'd9,          32'd9,          32'd0,          1'b1, 1'b0, 1});
      tbl.push_back('{3'd5, 32'hFFFFFFFF,   32'd1,          32'd1,          1'b0, 1'b0, 1});
      tbl.push_back('{3'd5, 32'd1,          32'hFFFFFFFF,   32'd0,          1'b1, 1'b0, 1});
      tbl.push_back('{3'd0, 32'hFFFFFFFF,   32'd1,          32'd0,          1'b1, 1'b0, 1});
      tbl.push_back('{3'd1, 32'd0,          32'd1,          32'hFFFFFFFF,   1'b0, 1'b0, 1});
      tbl.push_back('{3'd2, 32'hF0F0_1234,  32'h0FF0_FF00,  32'h00F0_1200,  1'b0, 1'b0, 1});
      tbl.push_back('{3'd3, 32'hF000_0001,  32'h0000_0100,  32'hF000_0101,  1'b0, 1'b0, 1});
      tbl.push_back('{3'd4, 32'hAAAA_5555,  32'hFFFF_0000,  32'h5555_5555,  1'b0, 1'b0, 1});
      tbl.push_back('{3'd7, 32'd123,        32'd456,        32'd0,          1'b1, 1'b1, 1});
`ifdef SEQ_ALU_MUL_EN
      tbl.push_back('{3'd6, 32'h0001_0001,  32'h0001_0001,  32'h0002_0001,  1'b0, 1'b0, 33});
      tbl.push_back('{3'd6, 32'hFFFF_FFFF,  32'd3,          32'hFFFF_FFFD,  1'b0, 1'b0, 33});
`else
      tbl.push_back('{3'd6, 32'h0001_0001,  32'h0001_0001,  32'd0,          1'b1, 1'b1, 1});
`endif

      foreach (tbl[i]) begin
         run_op(tbl[i].op, tbl[i].x, tbl[i].y, r_got, z_got, il_got, lat_got, busy_ok);
         check($sformatf("tbl%0d_result", i), r_got, tbl[i].res);
         check($sformatf("tbl%0d_zero", i), z_got, tbl[i].z);
         check($sformatf("tbl%0d_illegal", i), il_got, tbl[i].ill);
         check($sformatf("tbl%0d_latency", i), lat_got, tbl[i].lat);
         check($sformatf("tbl%0d_idle_after", i), in_ready, 1);
         if (tbl[i].lat > 1) check($sformatf("tbl%0d_busy", i), busy_ok, 1);
      end

      // Backpressure: result held while out_ready is low, competing request ignored
      ALUControl = 3'd0; a = 32'd3; b = 32'd4; in_valid = 1'b1; out_ready = 1'b0;
      @(posedge clk); #1;
      ALUControl = 3'd1; a = 32'd100; b = 32'd1;
      for (int i = 0; i < 5; i++) begin
         check("bp_out_valid", out_valid, 1);
         check("bp_result", result, 32'd7);
         check("bp_in_ready", in_ready, 0);
         @(posedge clk); #1;
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      check("bp_release_valid", out_valid, 0);
      check("bp_release_ready", in_ready, 1);
      @(posedge clk); #1;
      check("bp_no_ghost", out_valid, 0);

      // Reset while a result is waiting in DONE
      ALUControl = 3'd0; a = 32'd1; b = 32'd1; in_valid = 1'b1; out_ready = 1'b0;
      @(posedge clk); #1;
      in_valid = 1'b0;
      reset    = 1'b1;
      @(posedge clk); #1;
      reset     = 1'b0;
      out_ready = 1'b1;
      check("rst_done_out_valid", out_valid, 0);
      check("rst_done_in_ready", in_ready, 1);
      check("rst_done_result", result, 0);
      repeat (3) @(posedge clk);
      #1;
      check("rst_done_no_result", out_valid, 0);

`ifdef SEQ_ALU_MUL_EN
      // Reset ten cycles into a multiply
      ALUControl = 3'd6; a = 32'h0001_0001; b = 32'd3; in_valid = 1'b1; out_ready = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (10) @(posedge clk);
      #1;
      check("rst_mul_busy", in_ready, 0);
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      check("rst_mul_out_valid", out_valid, 0);
      check("rst_mul_in_ready", in_ready, 1);
      stale = 1'b0;
      for (int i = 0; i < 40; i++) begin
         if (out_valid) stale = 1'b1;
         @(posedge clk); #1;
      end
      check("rst_mul_no_stale", stale, 0);
`endif

      for (int i = 0; i < 40; i++) begin
         logic [2:0]  op;
         logic [31:0] x;
         logic [31:0] y;
         op = 3'($urandom_range(0, 7));
         x  = $urandom;
         y  = ($urandom_range(0, 3) == 0) ? x : $urandom;
         model(op, x, y, r_exp, il_exp, lat_exp);
         run_op(op, x, y, r_got, z_got, il_got, lat_got, busy_ok);
         check($sformatf("rnd%0d_op%0d_result", i, op), r_got, r_exp);
         check($sformatf("rnd%0d_op%0d_zero", i, op), z_got, (r_exp == 32'd0));
         check($sformatf("rnd%0d_op%0d_illegal", i, op), il_got, il_exp);
         check($sformatf("rnd%0d_op%0d_latency", i, op), lat_got, lat_exp);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/seq_alu.md
SEQ_ALU -- requirements
Module: seq_alu

Interface
REQ-001 Parameter: WIDTH, 32, operand and result width in bits.
REQ-002 Port: clk  input  1  rising-edge clock, the single clock of the block.
REQ-003 Port: reset  input  1  synchronous, active-high reset.
REQ-004 Port: in_valid  input  1  operation request present.
REQ-005 Port: in_ready  output  1  block can accept a request.
REQ-006 Port: ALUControl  input  3  operation code produced by the ALU decoder.
REQ-007 Port: a  input  WIDTH  first operand.
REQ-008 Port: b  input  WIDTH  second operand.
REQ-009 Port: out_valid  output  1  result available.
REQ-010 Port: out_ready  input  1  consumer takes result.
REQ-011 Port: result  output  WIDTH  operation result.
REQ-012 Port: zero  output  1  result equals zero.
REQ-013 Port: illegal  output  1  accepted code was not a supported operation.

Function
REQ-014 The opcodes SHALL be: 000 add, 001 sub, 010 and, 011 or, 100 xor, 101 slt (signed), 110 mul (low WIDTH bits), 111 illegal.
REQ-015 The block SHALL use a three-state FSM: IDLE, MUL, DONE.
REQ-016 in_ready SHALL be 1 exactly when the state is IDLE; a request is accepted on a cycle with in_valid=1 and in_ready=1.
REQ-017 For an accepted non-mul code, the FSM SHALL go IDLE->DONE, with result registered and out_valid=1 on the next cycle (latency 1).
REQ-018 For an accepted mul, the block SHALL latch a and b, go IDLE->MUL, and perform one shift-add step per cycle for WIDTH cycles, then go to DONE (out_valid asserted WIDTH+1 cycles after acceptance).
REQ-019 In DONE, result, zero, and illegal SHALL hold stable and out_valid SHALL stay 1 until a cycle with out_ready=1, after which the FSM returns to IDLE.
REQ-020 Requests presented while not IDLE SHALL be ignored; the consumer must hold in_valid and the operands.
REQ-021 The add, sub, and mul operations SHALL wrap modulo 2^WIDTH, with no overflow flag.
REQ-022 The slt operation SHALL produce 1 in bit 0 and zeros elsewhere when a < b (two's complement), else 0.
REQ-023 An illegal code SHALL produce result=0, zero=1, illegal=1, with latency 1.
REQ-024 The illegal output SHALL be 0 for every supported operation.
REQ-025 out_ready asserted while out_valid=0 SHALL have no effect.

Reset
REQ-026 On reset=1 at a clock edge, the state SHALL become IDLE, out_valid=0, result=0, zero=0, and illegal=0, and the multiplier accumulator and counter SHALL clear.
REQ-027 A reset during MUL or DONE SHALL discard the operation, and no result SHALL be presented afterwards.
REQ-028 On the cycle after reset deasserts, in_ready SHALL be 1.

Configuration
REQ-029 The macro SEQ_ALU_MUL_EN SHALL select multiplier support.
- Defined: code 110 is the iterative multiply of REQ-018.
- Undefined: code 110 is treated as illegal per REQ-023, the MUL state and multiplier are not built, and all latencies are 1.

Structure
REQ-030 The shared package alu_pkg SHALL hold the ALUControl encoding constants and the FSM state enum type.
REQ-031 The shift-add datapath (accumulator, shifted multiplicand, bit counter) SHALL be the sub-module mul_iter, instantiated only under SEQ_ALU_MUL_EN.

Verification
REQ-032 Add: a=7, b=5, ALUControl=000, out_ready=1 -> next cycle out_valid=1, result=12, zero=0; the cycle after that, in_ready=1.
REQ-033 Sub and zero: a=9, b=9, ALUControl=001 -> result=0, zero=1; slt with a=0xFFFFFFFF, b=1, ALUControl=101 -> result=1.
REQ-034 Mul (macro defined): a=0x10001, b=0x10001, ALUControl=110 -> out_valid exactly 33 cycles after acceptance, result=0x00020001; in_ready stays 0 throughout.
REQ-035 Backpressure: add 3+4 with out_ready=0 for 5 cycles -> out_valid=1 and result=7 held for those cycles, and a new in_valid is ignored; out_ready=1 -> IDLE on the next cycle.
REQ-036 Reset mid-mul: assert reset 10 cycles into a mul -> out_valid=0 and in_ready=1 after reset, with no stale result.
REQ-037 Illegal code: ALUControl=111 -> result=0, zero=1, illegal=1 after 1 cycle; with the macro undefined, ALUControl=110 gives the same response.
